// File: rtl/rvlab_jtag_idcode_test.sv
// rvlab_jtag_idcode_test: JTAG master that resets a TAP, loads IDCODE and reads the 32-bit ID; define RVLAB_JTAG_TRST_EN for a TRST pulse before the TAP reset
`timescale 1ns/1ps
module rvlab_jtag_idcode_test #(
  parameter int unsigned         CLK_DIV      = 4,
  parameter int unsigned         IR_LEN       = 5,
  parameter logic [IR_LEN-1:0]   IDCODE_INSTR = IR_LEN'(1),
  parameter logic [31:0]         EXP_IDCODE   = 32'h249511C3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        jtag_tck_o,
  output logic        jtag_tms_o,
  output logic        jtag_tdi_o,
  input  logic        jtag_tdo_i,
  output logic        jtag_trst_no,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [31:0] idcode_o
);
  localparam int unsigned MAXLEN = IR_LEN > 32 ? IR_LEN : 32;
  localparam int unsigned CW = $clog2(MAXLEN);
  localparam int unsigned DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [3:0] {
    IDLE, TRST, TAP_RST, TO_SHIFT_IR, SHIFT_IR, TO_SHIFT_DR, SHIFT_DR, EXIT, DONE
  } state_t;
  state_t st_q, st_d, st_n;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic [IR_LEN-1:0] ir_q, ir_d, ir_n;
  logic [31:0] sh_q, sh_d, id_q, id_d;
  logic tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic last;
  // index of the final TCK spent in each phase
  function automatic logic [CW-1:0] last_cnt(input state_t s);
    return s == TAP_RST ? CW'(5) : s == TO_SHIFT_IR ? CW'(3) : s == SHIFT_IR ? CW'(IR_LEN-1) :
           s == TO_SHIFT_DR ? CW'(4) : s == SHIFT_DR ? CW'(31) : CW'(1);
  endfunction
  // TMS value for TCK number c of phase s
  function automatic logic tms_of(input state_t s, input logic [CW-1:0] c);
    return s == TAP_RST ? c != CW'(5) : s == TO_SHIFT_IR ? c < CW'(2) :
           s == SHIFT_IR ? c == CW'(IR_LEN-1) : s == TO_SHIFT_DR ? (c == CW'(0) || c == CW'(2)) :
           s == SHIFT_DR ? c == CW'(31) : s == EXIT ? c == CW'(0) : 1'b1;
  endfunction
  function automatic state_t next_st(input state_t s);
    return s == TAP_RST ? TO_SHIFT_IR : s == TO_SHIFT_IR ? SHIFT_IR : s == SHIFT_IR ? TO_SHIFT_DR :
           s == TO_SHIFT_DR ? SHIFT_DR : s == SHIFT_DR ? EXIT : DONE;
  endfunction
  assign last  = cnt_q == last_cnt(st_q);
  assign st_n  = last ? next_st(st_q) : st_q;
  assign cnt_n = last ? '0 : cnt_q + CW'(1);
  assign ir_n  = st_q == SHIFT_IR ? ir_q >> 1 : ir_q;
`ifdef RVLAB_JTAG_TRST_EN
  logic trst_q, trst_d;
  assign jtag_trst_no = trst_q;
`else
  assign jtag_trst_no = 1'b1;
`endif
  // sequencer: TCK low half ends with a rising edge (TDO sample), high half ends with a falling edge (advance TMS/TDI)
  always_comb begin
    st_d = st_q;
    div_d = div_q;
    cnt_d = cnt_q;
    ir_d = ir_q;
    sh_d = sh_q;
    id_d = id_q;
    tck_d = tck_q;
    tms_d = tms_q;
    tdi_d = tdi_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
`ifdef RVLAB_JTAG_TRST_EN
    trst_d = trst_q;
`endif
    if (!busy_q) begin
      if (start_i) begin
`ifdef RVLAB_JTAG_TRST_EN
        st_d = TRST;
        trst_d = 1'b0;
`else
        st_d = TAP_RST;
`endif
        div_d = '0;
        cnt_d = '0;
        ir_d = IDCODE_INSTR;
        tck_d = 1'b0;
        tms_d = 1'b1;
        tdi_d = 1'b0;
        busy_d = 1'b1;
        done_d = 1'b0;
        pass_d = 1'b0;
      end
    end else if (div_q != DW'(CLK_DIV-1)) begin
      div_d = div_q + DW'(1);
    end else begin
      div_d = '0;
      if (st_q == TRST) begin
        cnt_d = CW'(1);
        if (cnt_q[0]) begin
          st_d = TAP_RST;
          cnt_d = '0;
`ifdef RVLAB_JTAG_TRST_EN
          trst_d = 1'b1;
`endif
        end
      end else if (!tck_q) begin
        tck_d = 1'b1;
        sh_d = st_q == SHIFT_DR ? {jtag_tdo_i, sh_q[31:1]} : sh_q;
      end else if (st_q == EXIT && last) begin
        tck_d = 1'b0;
        st_d = DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
        id_d = sh_q;
        pass_d = sh_q == EXP_IDCODE;
      end else begin
        tck_d = 1'b0;
        st_d = st_n;
        cnt_d = cnt_n;
        ir_d = ir_n;
        tms_d = tms_of(st_n, cnt_n);
        tdi_d = st_n == SHIFT_IR && ir_n[0];
      end
    end
  end
  // state and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q <= IDLE;
      div_q <= '0;
      cnt_q <= '0;
      ir_q <= '0;
      sh_q <= '0;
      id_q <= '0;
      tck_q <= 1'b0;
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
`ifdef RVLAB_JTAG_TRST_EN
      trst_q <= 1'b1;
`endif
    end else begin
      st_q <= st_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      ir_q <= ir_d;
      sh_q <= sh_d;
      id_q <= id_d;
      tck_q <= tck_d;
      tms_q <= tms_d;
      tdi_q <= tdi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
`ifdef RVLAB_JTAG_TRST_EN
      trst_q <= trst_d;
`endif
    end
  end
  assign jtag_tck_o = tck_q;
  assign jtag_tms_o = tms_q;
  assign jtag_tdi_o = tdi_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = pass_q;
  assign idcode_o = id_q;
endmodule

// File: tb/tb_rvlab_jtag_idcode_test.sv
// tb_rvlab_jtag_idcode_test: drives the JTAG master against a behavioural IEEE 1149.1 TAP model
`timescale 1ns/1ps
module tb_rvlab_jtag_idcode_test;
  localparam int CLK_DIV = 4;
  localparam logic [31:0] EXP = 32'h249511C3;
  localparam logic [4:0] IDC = 5'b00001;
`ifdef RVLAB_JTAG_TRST_EN
  localparam int TRST_CYC = 2*CLK_DIV;
`else
  localparam int TRST_CYC = 0;
`endif
  localparam int LAT = 54*2*CLK_DIV + TRST_CYC;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, tdo = 1'b0;
  logic tck, tms, tdi, trst_n, busy, done, pass;
  logic [31:0] idcode;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  rvlab_jtag_idcode_test #(.CLK_DIV(CLK_DIV), .IR_LEN(5), .IDCODE_INSTR(IDC), .EXP_IDCODE(EXP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .jtag_tck_o(tck), .jtag_tms_o(tms),
    .jtag_tdi_o(tdi), .jtag_tdo_i(tdo), .jtag_trst_no(trst_n), .busy_o(busy), .done_o(done),
    .pass_o(pass), .idcode_o(idcode));
  typedef enum logic [3:0] {TLR, RTI, SDS, CDR, SDR, E1D, PDR, E2D, UDR, SIS, CIR, SIR, E1I, PIR, E2I, UIR} tap_t;
  tap_t tap = TLR;
  logic [31:0] tap_id = 32'h0, dr = 32'h0;
  logic [4:0] ir_sh = 5'h0, ir = IDC;
  logic tms_log[$];
  logic ir_log[$];
  int trst_low = 0, tck_in_trst = 0;
  function automatic tap_t tap_next(input tap_t s, input logic t);
    case (s)
      TLR: return t ? TLR : RTI;
      RTI: return t ? SDS : RTI;
      SDS: return t ? SIS : CDR;
      CDR: return t ? E1D : SDR;
      SDR: return t ? E1D : SDR;
      E1D: return t ? UDR : PDR;
      PDR: return t ? E2D : PDR;
      E2D: return t ? UDR : SDR;
      UDR: return t ? SDS : RTI;
      SIS: return t ? TLR : CIR;
      CIR: return t ? E1I : SIR;
      SIR: return t ? E1I : SIR;
      E1I: return t ? UIR : PIR;
      PIR: return t ? E2I : PIR;
      E2I: return t ? UIR : SIR;
      default: return t ? SDS : RTI;
    endcase
  endfunction
  always @(posedge tck) begin
    if (!trst_n) tap = TLR;
    tms_log.push_back(tms);
    if (tap == SIR) begin
      ir_log.push_back(tdi);
      ir_sh = {tdi, ir_sh[4:1]};
    end
    if (tap == CDR) dr = ir == IDC ? tap_id : 32'h0;
    else if (tap == SDR) dr = {tdi, dr[31:1]};
    tap = tap_next(tap, tms);
    if (tap == UIR) ir = ir_sh;
    if (tap == TLR) ir = IDC;
  end
  always @(negedge tck) tdo = tap == SDR ? dr[0] : 1'b0;
  always @(negedge clk) if (!trst_n) begin
    trst_low++;
    if (tck) tck_in_trst++;
  end
  function automatic int tms_errs(input int base);
    logic exp[$];
    int e = 0;
    exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) exp.push_back(i == 4);
    exp.push_back(1'b1); exp.push_back(1'b0); exp.push_back(1'b1); exp.push_back(1'b0); exp.push_back(1'b0);
    for (int i = 0; i < 32; i++) exp.push_back(i == 31);
    exp.push_back(1'b1); exp.push_back(1'b0);
    if (tms_log.size() - base != 54) return 99;
    for (int i = 0; i < 54; i++) if (tms_log[base+i] !== exp[i]) e++;
    return e;
  endfunction
  task automatic run_id(input logic [31:0] id, output int cyc);
    tap_id = id;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < LAT + 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({tck, tms, tdi, trst_n, busy, done, pass, idcode} !== {4'b0101, 3'b000, 32'h0}) begin
      fails++;
      $display("FAIL reset_values: got %h expected %h", {tck, tms, tdi, trst_n, busy, done, pass, idcode}, {4'b0101, 3'b000, 32'h0});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_pass;
    int cyc, tb, ib, e;
    logic [4:0] irv;
    tb = tms_log.size();
    ib = ir_log.size();
    run_id(EXP, cyc);
    tests++;
    if (cyc !== LAT + 1) begin fails++; $display("FAIL pass_latency: got %0d expected %0d", cyc, LAT + 1); end
    tests++;
    if ({busy, done, pass} !== 3'b011) begin fails++; $display("FAIL pass_flags: got %b expected 011", {busy, done, pass}); end
    tests++;
    if (idcode !== EXP) begin fails++; $display("FAIL pass_idcode: got %h expected %h", idcode, EXP); end
    e = tms_errs(tb);
    tests++;
    if (e !== 0) begin fails++; $display("FAIL tms_pattern: got %0d wrong of %0d ticks expected 0 wrong of 54", e, tms_log.size() - tb); end
    irv = 5'h1f;
    if (ir_log.size() - ib == 5) for (int i = 0; i < 5; i++) irv[i] = ir_log[ib+i];
    tests++;
    if (irv !== IDC) begin fails++; $display("FAIL ir_bits: got %b expected %b", irv, IDC); end
  endtask
  task automatic test_fail;
    int cyc;
    run_id(32'h12345678, cyc);
    tests++;
    if ({done, pass, idcode} !== {2'b10, 32'h12345678}) begin
      fails++;
      $display("FAIL mismatch_id: got %b %b %h expected 1 0 12345678", done, pass, idcode);
    end
  endtask
  task automatic test_back_to_back;
    int cyc;
    logic [31:0] id;
    for (int n = 0; n < 6; n++) begin
      id = $urandom_range(0, 2) == 0 ? EXP : $urandom;
      run_id(id, cyc);
      tests++;
      if ({cyc == LAT + 1, done, pass, idcode} !== {2'b11, id == EXP, id}) begin
        fails++;
        $display("FAIL b2b_%0d: got cyc=%0d done=%b pass=%b id=%h expected cyc=%0d done=1 pass=%b id=%h",
                 n, cyc, done, pass, idcode, LAT + 1, id == EXP, id);
      end
    end
  endtask
  task automatic test_busy_ignore;
    int cyc, tb;
    logic [31:0] id;
    id = $urandom;
    tap_id = id;
    tb = tms_log.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({busy, done} !== 2'b10) begin fails++; $display("FAIL accept_flags: got %b expected 10", {busy, done}); end
    cyc = 1;
    repeat (149) begin @(negedge clk); cyc++; end
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    while (!done && cyc < LAT + 20) begin @(negedge clk); cyc++; end
    tests++;
    if ({cyc == LAT + 1, idcode, pass} !== {1'b1, id, id == EXP}) begin
      fails++;
      $display("FAIL busy_ignore: got cyc=%0d id=%h pass=%b expected cyc=%0d id=%h pass=%b", cyc, idcode, pass, LAT + 1, id, id == EXP);
    end
    tests++;
    if (tms_errs(tb) !== 0) begin fails++; $display("FAIL busy_ignore_tms: got %0d errors expected 0", tms_errs(tb)); end
  endtask
  task automatic test_reset_mid;
    int cyc;
    tap_id = EXP;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    tests++;
    if (tap !== SDR) begin fails++; $display("FAIL mid_in_shift_dr: got tap state %0d expected %0d", tap, SDR); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({tck, tms, tdi, trst_n, busy, done, pass, idcode} !== {4'b0101, 3'b000, 32'h0}) begin
      fails++;
      $display("FAIL mid_reset_values: got %h expected %h", {tck, tms, tdi, trst_n, busy, done, pass, idcode}, {4'b0101, 3'b000, 32'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_id(EXP, cyc);
    tests++;
    if ({cyc == LAT + 1, done, pass, idcode} !== {3'b111, EXP}) begin
      fails++;
      $display("FAIL after_reset_run: got cyc=%0d done=%b pass=%b id=%h expected cyc=%0d 1 1 %h", cyc, done, pass, idcode, LAT + 1, EXP);
    end
  endtask
  task automatic test_trst;
    int cyc, lo, tk;
    lo = trst_low;
    tk = tck_in_trst;
    run_id($urandom, cyc);
    tests++;
    if (trst_low - lo !== TRST_CYC) begin fails++; $display("FAIL trst_width: got %0d expected %0d", trst_low - lo, TRST_CYC); end
    tests++;
    if (tck_in_trst - tk !== 0) begin fails++; $display("FAIL trst_tck_low: got %0d cycles with tck high expected 0", tck_in_trst - tk); end
`ifndef RVLAB_JTAG_TRST_EN
    tests++;
    if (trst_low !== 0) begin fails++; $display("FAIL trst_constant: got %0d low cycles expected 0", trst_low); end
`endif
  endtask
  initial begin
    test_reset;
    test_pass;
    test_fail;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid;
    test_trst;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
